// File: rtl/time_tmr_lock_arbiter.sv
// Round-robin output arbiter for the time-redundant opgroup datapath.
// Locks onto one input until a full group of redundant copies has passed or the lock times out.
module time_tmr_lock_arbiter #(
   parameter int NumIn       = 3,
   parameter int DataWidth   = 32,
   parameter int IDSize      = 4,
   parameter int Redundancy  = 3,
   parameter int LockTimeout = 5
) (
   input  logic                        clk_i,
   input  logic                        rst_i,
   input  logic [NumIn-1:0]            req_i,
   output logic [NumIn-1:0]            gnt_o,
   input  logic [NumIn*DataWidth-1:0]  data_i,
   input  logic [NumIn*IDSize-1:0]     id_i,
   output logic                        req_o,
   input  logic                        gnt_i,
   output logic [DataWidth-1:0]        data_o,
   output logic [IDSize-1:0]           id_o,
   output logic [$clog2(NumIn)-1:0]    idx_o,
   output logic                        lock_o,
   output logic                        timeout_o,
   output logic                        id_mismatch_o
);

   // state  | meaning
   // IDLE   | round-robin selection, optionally holding a stalled pick
   // LOCKED | bound to lock_idx until the group completes or times out

   localparam int IdxW = $clog2(NumIn);
   localparam int CntW = $clog2(Redundancy + 1);
   localparam int TmoW = $clog2(LockTimeout + 1);
   localparam logic [CntW-1:0] RedC  = CntW'(Redundancy);
   localparam logic [TmoW-1:0] TmoC  = TmoW'(LockTimeout);
   localparam logic [IdxW-1:0] LastC = IdxW'(NumIn - 1);

   typedef enum logic {IDLE, LOCKED} state_e;

   state_e            state_q, state_d;
   logic [IdxW-1:0]   rr_q, rr_d;
   logic [CntW-1:0]   cnt_q, cnt_d;
   logic [TmoW-1:0]   tmo_q, tmo_d;
   logic              pend_q, pend_d;
   logic [IdxW-1:0]   pend_idx_q, pend_idx_d;
   logic [IdxW-1:0]   lock_idx_q, lock_idx_d;
   logic [IDSize-1:0] lock_id_q, lock_id_d;
   logic              timeout_q, timeout_d;
   logic              mism_q, mism_d;

   logic [IdxW-1:0]   rr_sel, sel;
   logic              found, hs;

   function automatic logic [IdxW-1:0] inc_idx(input logic [IdxW-1:0] i);
      return (i == LastC) ? '0 : i + 1'b1;
   endfunction

   always_comb begin
      rr_sel = rr_q;
      found  = 1'b0;
      for (int k = 0; k < NumIn; k++) begin
         int cand;
         cand = int'(rr_q) + k;
         if (cand >= NumIn) cand = cand - NumIn;
         if (!found && req_i[cand]) begin
            rr_sel = IdxW'(cand);
            found  = 1'b1;
         end
      end
   end

   always_comb begin
      if (state_q == LOCKED) sel = lock_idx_q;
      else if (pend_q)       sel = pend_idx_q;
      else                   sel = rr_sel;
   end

   always_comb begin
      data_o = '0;
      id_o   = '0;
      for (int i = 0; i < NumIn; i++) begin
         if (sel == IdxW'(i)) begin
            data_o = data_i[i*DataWidth +: DataWidth];
            id_o   = id_i[i*IDSize +: IDSize];
         end
      end
   end

   // Outputs are forced quiet while reset is held, regardless of register state.
   assign req_o         = req_i[sel] & ~rst_i;
   assign hs            = req_o & gnt_i;
   assign idx_o         = sel;
   assign lock_o        = (state_q == LOCKED) & ~rst_i;
   assign timeout_o     = timeout_q & ~rst_i;
   assign id_mismatch_o = mism_q & ~rst_i;

   always_comb begin
      gnt_o = '0;
      for (int i = 0; i < NumIn; i++) gnt_o[i] = hs && (sel == IdxW'(i));
   end

   always_comb begin
      state_d    = state_q;
      rr_d       = rr_q;
      cnt_d      = cnt_q;
      tmo_d      = tmo_q;
      pend_d     = pend_q;
      pend_idx_d = pend_idx_q;
      lock_idx_d = lock_idx_q;
      lock_id_d  = lock_id_q;
      timeout_d  = 1'b0;
      mism_d     = 1'b0;
      case (state_q)
         IDLE: begin
            if (hs) begin
               pend_d = 1'b0;
               if (Redundancy == 1) begin
                  rr_d = inc_idx(sel);
               end else begin
                  state_d    = LOCKED;
                  lock_idx_d = sel;
                  lock_id_d  = id_o;
                  cnt_d      = CntW'(1);
                  tmo_d      = '0;
               end
            end else if (req_o) begin
               pend_d     = 1'b1;
               pend_idx_d = sel;
            end
         end
         LOCKED: begin
            if (hs) begin
               tmo_d = '0;
               if (id_o == lock_id_q) begin
                  if (cnt_q + 1'b1 == RedC) begin
                     state_d = IDLE;
                     rr_d    = inc_idx(lock_idx_q);
                     cnt_d   = '0;
                  end else begin
                     cnt_d = cnt_q + 1'b1;
                  end
               end else begin
                  // foreign ID restarts the group on the same input
                  mism_d    = 1'b1;
                  lock_id_d = id_o;
                  cnt_d     = CntW'(1);
               end
            end else if (tmo_q + 1'b1 == TmoC) begin
               state_d   = IDLE;
               rr_d      = inc_idx(lock_idx_q);
               cnt_d     = '0;
               tmo_d     = '0;
               timeout_d = 1'b1;
            end else begin
               tmo_d = tmo_q + 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q    <= IDLE;
         rr_q       <= '0;
         cnt_q      <= '0;
         tmo_q      <= '0;
         pend_q     <= 1'b0;
         pend_idx_q <= '0;
         lock_idx_q <= '0;
         lock_id_q  <= '0;
         timeout_q  <= 1'b0;
         mism_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         rr_q       <= rr_d;
         cnt_q      <= cnt_d;
         tmo_q      <= tmo_d;
         pend_q     <= pend_d;
         pend_idx_q <= pend_idx_d;
         lock_idx_q <= lock_idx_d;
         lock_id_q  <= lock_id_d;
         timeout_q  <= timeout_d;
         mism_q     <= mism_d;
      end
   end

endmodule

// File: tb/tb_time_tmr_lock_arbiter.sv
// Directed bench for time_tmr_lock_arbiter with default parameters (3 inputs, groups of 3, timeout 5).
module tb_time_tmr_lock_arbiter;

   logic        clk_i = 1'b0;
   logic        rst_i;
   logic [2:0]  req_i;
   logic [2:0]  gnt_o;
   logic [95:0] data_i;
   logic [11:0] id_i;
   logic        req_o;
   logic        gnt_i;
   logic [31:0] data_o;
   logic [3:0]  id_o;
   logic [1:0]  idx_o;
   logic        lock_o;
   logic        timeout_o;
   logic        id_mismatch_o;

   int total = 0;
   int bad   = 0;

   time_tmr_lock_arbiter dut (
      .clk_i(clk_i), .rst_i(rst_i), .req_i(req_i), .gnt_o(gnt_o),
      .data_i(data_i), .id_i(id_i), .req_o(req_o), .gnt_i(gnt_i),
      .data_o(data_o), .id_o(id_o), .idx_o(idx_o), .lock_o(lock_o),
      .timeout_o(timeout_o), .id_mismatch_o(id_mismatch_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic set_id(input int i, input logic [3:0] v);
      id_i[i*4 +: 4] = v;
   endtask

   initial begin
      int exp_order[4];
      rst_i  = 1'b1;
      gnt_i  = 1'b1;
      req_i  = 3'b111;
      data_i = {32'hCAFE_0002, 32'hCAFE_0001, 32'hCAFE_0000};
      id_i   = {4'd6, 4'd5, 4'd2};

      // reset: outputs held quiet even with requests present
      tick();
      #1;
      chk("rst_req_o", 32'(req_o), 32'd0);
      chk("rst_gnt_o", 32'(gnt_o), 32'd0);
      chk("rst_lock_o", 32'(lock_o), 32'd0);
      chk("rst_timeout_o", 32'(timeout_o), 32'd0);
      chk("rst_mism_o", 32'(id_mismatch_o), 32'd0);

      // group on input0 moves rr pointer to 1
      rst_i = 1'b0;
      req_i = 3'b001;
      #1;
      chk("a1_idx", 32'(idx_o), 32'd0);
      chk("a1_gnt", 32'(gnt_o), 32'b001);
      chk("a1_lock", 32'(lock_o), 32'd0);
      tick();
      chk("a2_lock", 32'(lock_o), 32'd1);
      tick();
      chk("a3_gnt", 32'(gnt_o), 32'b001);
      tick();

      // basic lock: input1 ID 5 three times while others request
      req_i = 3'b111;
      #1;
      chk("b1_idx", 32'(idx_o), 32'd1);
      chk("b1_gnt", 32'(gnt_o), 32'b010);
      chk("b1_id", 32'(id_o), 32'd5);
      chk("b1_data", data_o, 32'hCAFE_0001);
      chk("b1_lock", 32'(lock_o), 32'd0);
      tick();
      chk("b2_lock", 32'(lock_o), 32'd1);
      chk("b2_gnt", 32'(gnt_o), 32'b010);
      tick();
      chk("b3_lock", 32'(lock_o), 32'd1);
      chk("b3_gnt", 32'(gnt_o), 32'b010);
      tick();
      chk("b4_lock", 32'(lock_o), 32'd0);
      chk("b4_idx", 32'(idx_o), 32'd2);

      // backpressure: input2 selection held for 4 stalled cycles
      gnt_i = 1'b0;
      for (int c = 0; c < 4; c++) begin
         #1;
         chk("bp_idx", 32'(idx_o), 32'd2);
         chk("bp_data", data_o, 32'hCAFE_0002);
         chk("bp_gnt", 32'(gnt_o), 32'd0);
         chk("bp_req_o", 32'(req_o), 32'd1);
         tick();
      end
      gnt_i = 1'b1;
      #1;
      chk("bp_rel_gnt", 32'(gnt_o), 32'b100);
      tick();
      chk("bp_lock_idx", 32'(idx_o), 32'd2);
      chk("bp_lock_gnt", 32'(gnt_o), 32'b100);
      tick();
      tick();

      // timeout: one HS of ID 7 on input0, then input0 goes quiet
      req_i = 3'b011;
      set_id(0, 4'd7);
      #1;
      chk("t0_idx", 32'(idx_o), 32'd0);
      chk("t0_id", 32'(id_o), 32'd7);
      chk("t0_gnt", 32'(gnt_o), 32'b001);
      tick();
      req_i = 3'b010;
      for (int c = 1; c <= 5; c++) begin
         #1;
         chk("t_wait_lock", 32'(lock_o), 32'd1);
         chk("t_wait_gnt", 32'(gnt_o), 32'd0);
         chk("t_wait_pulse", 32'(timeout_o), 32'd0);
         tick();
      end
      chk("t_pulse", 32'(timeout_o), 32'd1);
      chk("t_unlock", 32'(lock_o), 32'd0);
      chk("t_next_idx", 32'(idx_o), 32'd1);
      chk("t_next_gnt", 32'(gnt_o), 32'b010);
      tick();
      chk("t_pulse_end", 32'(timeout_o), 32'd0);
      chk("t_relock", 32'(lock_o), 32'd1);
      tick();
      tick();

      // ID mismatch: input0 locked on ID 3, then presents ID 4
      req_i = 3'b001;
      set_id(0, 4'd3);
      #1;
      chk("m1_idx", 32'(idx_o), 32'd0);
      chk("m1_gnt", 32'(gnt_o), 32'b001);
      tick();
      set_id(0, 4'd4);
      #1;
      chk("m2_mism", 32'(id_mismatch_o), 32'd0);
      chk("m2_lock", 32'(lock_o), 32'd1);
      tick();
      chk("m3_mism", 32'(id_mismatch_o), 32'd1);
      chk("m3_lock", 32'(lock_o), 32'd1);
      chk("m3_idx", 32'(idx_o), 32'd0);
      tick();
      chk("m4_mism", 32'(id_mismatch_o), 32'd0);
      chk("m4_lock", 32'(lock_o), 32'd1);
      tick();
      req_i = 3'b000;
      #1;
      chk("m5_lock", 32'(lock_o), 32'd0);
      chk("m5_req_o", 32'(req_o), 32'd0);

      // mid-group reset after 2 of 3 copies on input1
      req_i = 3'b111;
      #1;
      chk("r1_idx", 32'(idx_o), 32'd1);
      tick();
      tick();
      rst_i = 1'b1;
      #1;
      chk("r_req_o", 32'(req_o), 32'd0);
      chk("r_lock", 32'(lock_o), 32'd0);
      chk("r_gnt", 32'(gnt_o), 32'd0);
      tick();
      rst_i = 1'b0;
      #1;
      chk("r_after_lock", 32'(lock_o), 32'd0);

      // fairness: continuous groups from all inputs, order 0,1,2,0
      exp_order = '{0, 1, 2, 0};
      for (int g = 0; g < 4; g++) begin
         for (int b = 0; b < 3; b++) begin
            #1;
            chk("fair_idx", 32'(idx_o), 32'(exp_order[g]));
            chk("fair_gnt", 32'(gnt_o), 32'(1) << exp_order[g]);
            chk("fair_lock", 32'(lock_o), (b == 0) ? 32'd0 : 32'd1);
            tick();
         end
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
